pipeline_hazard_ctrl: RTL and testbench

//  Parametrised hazard controller for the in-order MIPS pipelines. It replaces the

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/hazard_match.sv | 43 ++++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the in-order pipeline hazard controller.
package pipe_pkg;

  // Widest register number a tracker entry can hold; REG_W must not exceed it.
  localparam int MAX_REG_W = 8;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_REGFILE = 0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] dest;
    logic                 wr;
    logic                 ld;
  } trk_entry_t;

  // Width of a forward select able to encode 0 (regfile) and 1..depth.
  function automatic int fwd_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand priority search over the tracked post-issue stages.
// Returns the youngest stage producing the operand and whether that
// producer is a load whose data is not yet available.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int REG_W      = 5,
  parameter int FW         = fwd_w(DEPTH)
) (
  input  trk_entry_t [DEPTH-1:0] entries,
  input  logic [REG_W-1:0]       src,
  input  logic                   src_used,
  output logic [FW-1:0]          fwd,
  output logic                   ld_not_ready
);

  logic [MAX_REG_W-1:0] src_ext_s;
  logic [DEPTH-1:0]     hit_s;

  assign src_ext_s = MAX_REG_W'(src);

  // Flag every stage whose pending write targets this operand ($0 never matches).
  always_comb begin
    hit_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit_s[k] = entries[k].valid & entries[k].wr & (entries[k].dest == src_ext_s)
                 & (src != '0) & src_used;
    end
  end

  // Scan oldest to youngest so the youngest (lowest-index) hit ends up winning.
  always_comb begin
    fwd          = FW'(FWD_REGFILE);
    ld_not_ready = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      fwd          = hit_s[k] ? FW'(k + 1) : fwd;
      ld_not_ready = hit_s[k] ? (entries[k].ld & ((k + 1) < LOAD_STAGE)) : ld_not_ready;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Parametrised forward/stall/flush controller for the in-order MIPS pipelines.
// A shift register tracks dest/RegWrite/load of every instruction in the
// DEPTH post-issue stages; forward selects and the load-use stall are derived
// combinationally from it, and stall/flush events are counted with saturation.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int REG_W      = 5,
  parameter int STAT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [REG_W-1:0]          rs,
  input  logic [REG_W-1:0]          rt,
  input  logic                      rs_used,
  input  logic                      rt_used,
  input  logic [REG_W-1:0]          dest,
  input  logic                      reg_write,
  input  logic                      is_load,
  input  logic                      branch_taken,
  output logic [fwd_w(DEPTH)-1:0]   fwd_a,
  output logic [fwd_w(DEPTH)-1:0]   fwd_b,
  output logic                      stall,
  output logic                      flush,
  output logic [STAT_W-1:0]         stall_cnt,
  output logic [STAT_W-1:0]         flush_cnt
);

  localparam int FW = fwd_w(DEPTH);

  // Index 0 is stage 1 (youngest), index DEPTH-1 is the regfile-writing stage.
  trk_entry_t [DEPTH-1:0] trk_r;
  trk_entry_t             issue_entry_s;
  logic [FW-1:0]          match_a_s;
  logic [FW-1:0]          match_b_s;
  logic                   ldnr_a_s;
  logic                   ldnr_b_s;
  logic                   stall_s;
  logic                   flush_s;
  logic [STAT_W-1:0]      stall_cnt_r;
  logic [STAT_W-1:0]      flush_cnt_r;

  // Increment unless already at all-ones.
  function automatic logic [STAT_W-1:0] sat_next(input logic [STAT_W-1:0] cur,
                                                 input logic              ev);
    return (ev && (cur != '1)) ? cur + STAT_W'(1) : cur;
  endfunction

  // Pack the issuing instruction into a tracker entry.
  always_comb begin
    issue_entry_s       = '0;
    issue_entry_s.valid = 1'b1;
    issue_entry_s.dest  = MAX_REG_W'(dest);
    issue_entry_s.wr    = reg_write;
    issue_entry_s.ld    = is_load;
  end

  hazard_match #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .REG_W      (REG_W),
    .FW         (FW)
  ) u_match_a (
    .entries      (trk_r),
    .src          (rs),
    .src_used     (rs_used),
    .fwd          (match_a_s),
    .ld_not_ready (ldnr_a_s)
  );

  hazard_match #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .REG_W      (REG_W),
    .FW         (FW)
  ) u_match_b (
    .entries      (trk_r),
    .src          (rt),
    .src_used     (rt_used),
    .fwd          (match_b_s),
    .ld_not_ready (ldnr_b_s)
  );

  // Load-use stall wins over a branch; forwards are zeroed while stalled.
  always_comb begin
    stall_s = issue_valid & (ldnr_a_s | ldnr_b_s);
    flush_s = branch_taken & issue_valid & ~stall_s;
    fwd_a   = stall_s ? FW'(FWD_REGFILE) : match_a_s;
    fwd_b   = stall_s ? FW'(FWD_REGFILE) : match_b_s;
  end

  // Advance the tracker; a stalled or empty issue slot inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_r <= '0;
    end else begin
      trk_r[0] <= (issue_valid && !stall_s) ? issue_entry_s : '0;
      for (int k = 1; k < DEPTH; k++) begin
        trk_r[k] <= trk_r[k-1];
      end
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      stall_cnt_r <= sat_next(stall_cnt_r, stall_s);
      flush_cnt_r <= sat_next(flush_cnt_r, flush_s);
    end
  end

  assign stall     = stall_s;
  assign flush     = flush_s;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: two controllers share one instruction stream.
// d2: DEPTH=2, LOAD_STAGE=2, STAT_W=16.  d3: DEPTH=3, LOAD_STAGE=2, STAT_W=2
// (narrow counters so saturation is reached in a few stalls).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] rs, rt, dest;
  logic       rs_used, rt_used, reg_write, is_load, branch_taken;

  logic [1:0]  fwd_a2, fwd_b2, fwd_a3, fwd_b3;
  logic        stall2, flush2, stall3, flush3;
  logic [15:0] stall_cnt2, flush_cnt2;
  logic [1:0]  stall_cnt3, flush_cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DEPTH(2), .LOAD_STAGE(2), .REG_W(5), .STAT_W(16)) d2 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .rs(rs), .rt(rt),
    .rs_used(rs_used), .rt_used(rt_used), .dest(dest), .reg_write(reg_write),
    .is_load(is_load), .branch_taken(branch_taken), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .stall(stall2), .flush(flush2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  pipeline_hazard_ctrl #(.DEPTH(3), .LOAD_STAGE(2), .REG_W(5), .STAT_W(2)) d3 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .rs(rs), .rt(rt),
    .rs_used(rs_used), .rt_used(rt_used), .dest(dest), .reg_write(reg_write),
    .is_load(is_load), .branch_taken(branch_taken), .fwd_a(fwd_a3), .fwd_b(fwd_b3),
    .stall(stall3), .flush(flush3), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one issue-slot's inputs after the falling edge, let them settle.
  task automatic drive(input logic iv, input logic [4:0] s, input logic [4:0] t,
                       input logic su, input logic tu, input logic [4:0] d,
                       input logic w, input logic l, input logic br);
    @(negedge clk);
    issue_valid = iv; rs = s; rt = t; rs_used = su; rt_used = tu;
    dest = d; reg_write = w; is_load = l; branch_taken = br;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; rs = 5'd0; rt = 5'd0; rs_used = 1'b0; rt_used = 1'b0;
    dest = 5'd0; reg_write = 1'b0; is_load = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_fwd_a2", fwd_a2, 0);      chk("rst_fwd_b3", fwd_b3, 0);
    chk("rst_stall2", stall2, 0);      chk("rst_flush3", flush3, 0);
    chk("rst_scnt2", stall_cnt2, 0);   chk("rst_fcnt3", flush_cnt3, 0);

    // 1: add $3 ; add $4,$3,$3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("t1_first_fwd_a2", fwd_a2, 0);
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("t1_fwd_a2", fwd_a2, 1);   chk("t1_fwd_b2", fwd_b2, 1);
    chk("t1_stall2", stall2, 0);   chk("t1_fwd_a3", fwd_a3, 1);

    // 2: lw $3 ; nop ; add $5,$3,$0
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("t2_fwd_a3", fwd_a3, 2);   chk("t2_fwd_b3", fwd_b3, 0);
    chk("t2_stall3", stall3, 0);   chk("t2_fwd_a2", fwd_a2, 2);
    // lw $3 now in stage 3 of d3 (regfile writer) and gone from d2
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("t2_last_fwd_a3", fwd_a3, 3);  chk("t2_last_fwd_b3", fwd_b3, 3);
    chk("t2_gone_fwd_a2", fwd_a2, 0);

    // 3: lw $8 ; add $9,$8,$0
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("t3_stall2", stall2, 1);   chk("t3_stall3", stall3, 1);
    chk("t3_stall_fwd_a2", fwd_a2, 0);
    chk("t3_scnt_before", stall_cnt2, 0);
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("t3_release_stall2", stall2, 0);
    chk("t3_fwd_a2", fwd_a2, 2);   chk("t3_scnt2", stall_cnt2, 1);

    // 4: add $3 ; add $3 ; sub $6,$3,$0
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("t4_waw_fwd_a2", fwd_a2, 1);  chk("t4_waw_fwd_a3", fwd_a3, 1);
    // lw $0 then add $10,$0,$6: $0 never forwards nor stalls
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("t4_zero_fwd_a2", fwd_a2, 0);  chk("t4_zero_stall2", stall2, 0);
    chk("t4_fwd_b2", fwd_b2, 2);

    // 5: beq taken, not stalled
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("t5_flush2", flush2, 1);   chk("t5_fcnt_before", flush_cnt2, 0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_flush_off", flush2, 0); chk("t5_fcnt2", flush_cnt2, 1);
    // lw $11 ; beq $11,$0 taken -> stall first, flush after
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd11, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("t5_ld_stall2", stall2, 1); chk("t5_ld_flush2", flush2, 0);
    drive(1'b1, 5'd11, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("t5_late_flush2", flush2, 1); chk("t5_late_stall2", stall2, 0);
    chk("t5_scnt2", stall_cnt2, 2);   chk("t5_fcnt_hold", flush_cnt2, 1);

    // 6a: saturation of the 2-bit counter in d3 (2 -> 3 -> stays 3)
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    chk("t6_stall3_a", stall3, 1);
    drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    chk("t6_scnt3_top", stall_cnt3, 3);
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd14, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
    chk("t6_stall3_b", stall3, 1);
    drive(1'b1, 5'd14, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
    chk("t6_scnt3_sat", stall_cnt3, 3);  chk("t6_scnt2", stall_cnt2, 4);

    // 6b: reset asserted during a stall
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd16, 5'd0, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0);
    chk("t6_pre_rst_stall2", stall2, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 5'd16, 5'd0, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0);
    chk("t6_post_stall2", stall2, 0);   chk("t6_post_fwd_a2", fwd_a2, 0);
    chk("t6_post_scnt2", stall_cnt2, 0); chk("t6_post_fcnt2", flush_cnt2, 0);
    chk("t6_post_scnt3", stall_cnt3, 0); chk("t6_post_fwd_a3", fwd_a3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
